// File: rtl/rnd_sched_pkg.sv
// Shared types and width helpers for the random-word scheduler.
package rnd_sched_pkg;

   // Scheduler FSM: discard warmup samples, then serve requesters.
   typedef enum logic {
      WARM = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Default generator and delivered-word widths.
   localparam int DEF_SRC_W  = 63;
   localparam int DEF_WORD_W = 32;

   // Lowest sample bit that reaches a consumer; bits below it are dropped.
   function automatic int slice_lo(input int src_w, input int word_w);
      return src_w - word_w;
   endfunction

   // Round-robin pointer width for n requesters.
   function automatic int ptr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Occupancy counter width: must hold 0..depth inclusive.
   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rnd_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ. Produces nothing when en is low.
module rr_arbiter
   import rnd_sched_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int PW    = ptr_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   input  logic             en,
   output logic [N_REQ-1:0] win,
   output logic [PW-1:0]    win_idx
);

   logic found;
   int   cand;

   // Scan requesters starting at the pointer; the first hit wins.
   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      cand    = 0;
      if (en) begin
         for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && req[cand]) begin
               found   = 1'b1;
               win_idx = PW'(cand);
               win     = N_REQ'(1) << cand;
            end
         end
      end
   end

endmodule

// File: rtl/rnd_sched.sv
// Shares one xoroshiro128+ generator among N_REQ consumers. The generator
// is stepped only when a sample is actually consumed, WARMUP samples are
// dropped after reset, and words are prefetched into a small ring buffer
// that is drained one word per grant in round-robin order.
//
// Handshake: rnd_step is a combinational request to advance the generator
// at the coming edge; the value on rnd_in in that cycle is the consumed
// sample. gnt is a registered one-hot pulse and rnd_out is meaningful only
// in the cycle gnt is nonzero. req is a level; there is no per-requester
// memory, so dropping req before a grant simply withdraws the request.
module rnd_sched
   import rnd_sched_pkg::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int WORD_W = DEF_WORD_W,
   parameter  int SRC_W  = DEF_SRC_W,
   parameter  int DEPTH  = 2,
   parameter  int WARMUP = 4,
   localparam int LW     = lvl_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [SRC_W-1:0]  rnd_in,
   output logic              rnd_step,
   input  logic [N_REQ-1:0]  req,
   output logic [N_REQ-1:0]  gnt,
   output logic [WORD_W-1:0] rnd_out,
   output logic [LW-1:0]     level,
   output logic              ready
);

   localparam int PW       = ptr_w(N_REQ);
   localparam int AW       = $clog2(DEPTH);
   localparam int WW       = $clog2(WARMUP + 1);
   localparam int SLICE_LO = slice_lo(SRC_W, WORD_W);

   state_t            state_q, state_d;
   logic [WW-1:0]     warm_q;
   logic [WORD_W-1:0] fifo_q [DEPTH];
   logic [AW-1:0]     rd_q, wr_q;
   logic [LW-1:0]     level_q;
   logic [PW-1:0]     ptr_q;
   logic [N_REQ-1:0]  gnt_q;
   logic [WORD_W-1:0] rnd_out_q;

   logic              arb_en;
   logic [N_REQ-1:0]  win;
   logic [PW-1:0]     win_idx;
   logic              pop;
   logic              push;
   logic              unused_low_bits;

   // Only the top WORD_W bits of a sample are ever delivered.
   assign unused_low_bits = ^rnd_in[SLICE_LO-1:0];

   // Arbitrate only when serving and there is a word to hand out.
   assign arb_en = (state_q == RUN) && (level_q != '0);

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .en      (arb_en),
      .win     (win),
      .win_idx (win_idx)
   );

   assign pop  = |win;
   assign push = (state_q == RUN) && rnd_step;

   // Next state and generator step: always step while warming; in RUN step
   // to refill a non-full buffer or to replace the word being popped.
   always_comb begin
      state_d  = state_q;
      rnd_step = 1'b0;
      if (!reset) begin
         case (state_q)
            WARM: begin
               rnd_step = 1'b1;
               if (warm_q == WW'(WARMUP - 1)) state_d = RUN;
            end
            RUN: rnd_step = (level_q < LW'(DEPTH)) || pop;
            default: state_d = WARM;
         endcase
      end
   end

   // Control state, buffer pointers, RR pointer and registered grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= WARM;
         warm_q    <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         level_q   <= '0;
         ptr_q     <= '0;
         gnt_q     <= '0;
         rnd_out_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == WARM) warm_q <= warm_q + WW'(1);
         if (push) wr_q <= wr_q + AW'(1);
         if (pop) begin
            rd_q      <= rd_q + AW'(1);
            gnt_q     <= win;
            rnd_out_q <= fifo_q[rd_q];
            ptr_q     <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
         end else begin
            gnt_q     <= '0;
            rnd_out_q <= '0;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Buffer storage; a stepped sample lands at the tail on the same edge.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_q] <= rnd_in[SRC_W-1 -: WORD_W];
   end

   assign gnt     = gnt_q;
   assign rnd_out = rnd_out_q;
   assign level   = level_q;
   assign ready   = (state_q == RUN);

endmodule

// File: tb/tb_rnd_sched.sv
// Bench for rnd_sched: a generator stand-in feeds a prerandomized sample
// list, a reference model predicts every cycle from the behavioural rules,
// and a monitor compares each grant against the expected queue.
module tb_rnd_sched;

   localparam int N_REQ  = 4;
   localparam int WORD_W = 32;
   localparam int SRC_W  = 63;
   localparam int DEPTH  = 2;
   localparam int WARMUP = 4;
   localparam int LW     = $clog2(DEPTH + 1);
   localparam int GEN_N  = 4096;
   localparam int EW     = N_REQ + WORD_W;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [SRC_W-1:0]  rnd_in;
   logic              rnd_step;
   logic [N_REQ-1:0]  req = '0;
   logic [N_REQ-1:0]  gnt;
   logic [WORD_W-1:0] rnd_out;
   logic [LW-1:0]     level;
   logic              ready;

   always #5 clk = ~clk;

   rnd_sched #(
      .N_REQ(N_REQ), .WORD_W(WORD_W), .SRC_W(SRC_W), .DEPTH(DEPTH), .WARMUP(WARMUP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rnd_in   (rnd_in),
      .rnd_step (rnd_step),
      .req      (req),
      .gnt      (gnt),
      .rnd_out  (rnd_out),
      .level    (level),
      .ready    (ready)
   );

   // ---------------- generator stand-in ----------------
   logic [SRC_W-1:0] gen_mem [GEN_N];
   int               gidx = 0;

   assign rnd_in = gen_mem[gidx % GEN_N];

   always @(posedge clk) begin
      if (rnd_step === 1'b1) gidx <= gidx + 1;
   end

   // ---------------- scoreboard ----------------
   int            n_cmp  = 0;
   int            n_fail = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Abstract view: a word queue, a countdown of samples still to discard,
   // a round-robin start index and a cursor into the sample list.
   logic [WORD_W-1:0] m_buf[$];
   int                m_warm = WARMUP;
   int                m_ptr  = 0;
   int                m_gidx = 0;

   always @(negedge clk) begin
      bit               grant;
      bit               exp_step;
      int               win;
      logic [N_REQ-1:0] oh;
      logic [SRC_W-1:0] smp;
      if (reset) begin
         check("rnd_step_in_reset", 64'(rnd_step), 64'd0);
         m_buf.delete();
         m_warm = WARMUP;
         m_ptr  = 0;
      end else begin
         check("ready", 64'(ready), 64'(m_warm == 0));
         check("level", 64'(level), 64'(m_buf.size()));
         if (m_warm > 0) begin
            check("rnd_step_warm", 64'(rnd_step), 64'd1);
            m_warm--;
            m_gidx++;
         end else begin
            grant = 1'b0;
            win   = 0;
            if (m_buf.size() > 0) begin
               for (int k = 0; k < N_REQ; k++) begin
                  if (!grant && req[(m_ptr + k) % N_REQ]) begin
                     grant = 1'b1;
                     win   = (m_ptr + k) % N_REQ;
                  end
               end
            end
            exp_step = (m_buf.size() < DEPTH) || grant;
            check("rnd_step_run", 64'(rnd_step), 64'(exp_step));
            if (grant) begin
               oh      = '0;
               oh[win] = 1'b1;
               exp_q.push_back({oh, m_buf.pop_front()});
               m_ptr = (win + 1) % N_REQ;
            end
            if (exp_step) begin
               smp = gen_mem[m_gidx % GEN_N];
               m_buf.push_back(smp[SRC_W-1 -: WORD_W]);
               m_gidx++;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      logic [EW-1:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("gnt", 64'(gnt), 64'(e[EW-1 -: N_REQ]));
         check("rnd_out", 64'(rnd_out), 64'(e[WORD_W-1:0]));
      end else begin
         check("gnt_idle", 64'(gnt), 64'd0);
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic rst, input logic [N_REQ-1:0] rq, input int n);
      reset = rst;
      req   = rq;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      logic             r_rst;
      logic [N_REQ-1:0] r_req;
      for (int i = 0; i < GEN_N; i++) gen_mem[i] = SRC_W'({$urandom(), $urandom()});

      // Reset, warmup, then all requesters active.
      drive(1'b1, 4'b1111, 3);
      drive(1'b0, 4'b1111, 24);
      // Single requester, then a set that forces the pointer to wrap.
      drive(1'b0, 4'b0100, 10);
      drive(1'b0, 4'b0011, 6);
      // Idle until the buffer is full, then a single one-cycle request.
      drive(1'b0, 4'b0000, 10);
      drive(1'b0, 4'b0001, 1);
      drive(1'b0, 4'b0000, 3);
      // Reset with a full buffer and active requests.
      drive(1'b1, 4'b1111, 1);
      drive(1'b0, 4'b1111, 14);
      // Reset then a lone high requester waiting on an empty buffer.
      drive(1'b1, 4'b1000, 1);
      drive(1'b0, 4'b1000, 12);

      // Random request patterns with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         r_rst = ($urandom_range(0, 199) == 0);
         r_req = ($urandom_range(0, 5) == 0) ? '0 : N_REQ'($urandom_range(0, 15));
         drive(r_rst, r_req, 1);
      end

      drive(1'b0, 4'b0000, 4);
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rnd_sched.md
Name: rnd_sched

Overview:
- Shares one xoroshiro128+ generator (`rnd`, 63-bit `out`) between N_REQ consumers.
- Steps the generator only when a fresh word is needed and discards WARMUP initial samples after reset.
- Prefetches words into a small buffer and serves requesters round-robin, one 32-bit word per grant.
- Guarantees no generator sample is delivered twice; sits between `rnd` and downstream consumers such as `shuff`.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_W, 32, delivered word width; taken from the top bits of the sample.
- SRC_W, 63, generator output width.
- DEPTH, 2, prefetch buffer entries (power of 2, at least 2).
- WARMUP, 4, samples discarded after reset (at least 1).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- rnd_in, in, SRC_W, current generator output.
- rnd_step, out, 1, advance generator at this clock edge.
- req, in, N_REQ, per-requester request level.
- gnt, out, N_REQ, one-hot grant pulse, registered.
- rnd_out, out, WORD_W, word for the granted requester; valid only while gnt is nonzero.
- level, out, clog2(DEPTH+1), buffer occupancy.
- ready, out, 1, warmup complete.

Behaviour:
- One clock; reset is synchronous and active-high. `clk` and `reset` are the only clock/reset.
- Reset values: rnd_step=0, gnt=0, rnd_out=0, level=0, ready=0, RR pointer=0, state=WARM, warm counter=0.
- Reset mid-operation: on the next edge the buffer is flushed, any pending grant is dropped and gnt=0. Warmup reruns in full.
- Sampling rule: in a cycle where rnd_step=1, rnd_in[SRC_W-1 -: WORD_W] (bits 62:31) is the consumed sample. The generator updates at that edge, so each sample is consumed exactly once. Low bits are never used.
- FSM states:
  - WARM: rnd_step=1 every cycle and samples are discarded. After WARMUP steps, go to RUN. ready rises in the first RUN cycle.
  - RUN: rnd_step = (level < DEPTH) OR pop_this_cycle. A stepped sample is pushed to the buffer tail in the same cycle.
- Arbitration, RUN only:
  - Active when level > 0 and req is nonzero.
  - Pick the first set req bit at or after the RR pointer, wrapping modulo N_REQ.
  - Next cycle: gnt is one-hot at that index and rnd_out holds the buffer head. The head pops at the same edge.
  - The pointer then moves to winner+1, wrapping N_REQ-1 to 0.
- Latency: req to gnt is 1 cycle when the buffer is non-empty. The first word is available 1 cycle after ready.
- Throughput: push and pop in the same cycle is allowed at level==DEPTH. This sustains one grant per cycle.
- gnt is a single-cycle pulse. A requester holding req high gets repeated grants in RR turn.
- Dropping req before a grant cancels that request; no state is kept per requester.
- Empty buffer: no grant is issued even if req is set. The pointer does not move.
- In WARM, gnt stays 0 regardless of req.
- level is the true count after each edge and never exceeds DEPTH. Counter wrap is impossible.

Decomposition:
- Package rnd_sched_pkg:
  - state enum {WARM, RUN};
  - localparams for the WORD_W slice offset (SRC_W-WORD_W);
  - clog2-based widths for the pointer and level.
- Sub-module rr_arbiter (N_REQ):
  - inputs: req, pointer, enable;
  - outputs: one-hot winner and its index;
  - purely combinational.
- Buffer, FSM and output registers live in rnd_sched.

Test Plan:
- Reset, then release with req=4'b1111 → rnd_step high for exactly 4 cycles and gnt=0 throughout. ready=1 on cycle 5. First grant goes to requester 0 one cycle after a word is buffered.
- req=4'b1111 held in RUN → gnt sequence 0001,0010,0100,1000,0001, one grant per cycle. Each rnd_out equals model sample[62:31] in generator order, with no repeats.
- req=4'b0100 only → every grant goes to 2 at one per cycle. Then switch req to 4'b0011 → the next grant goes to 0 (pointer wraps from 3), then 1.
- req=0 for 10 cycles in RUN → level settles at 2 and rnd_step stays 0. Then req=4'b0001 for 1 cycle → one grant with the oldest buffered sample, and rnd_step=1 in the pop cycle.
- Assert reset for 1 cycle while level=2 and req is active → gnt=0 next cycle and level=0. The warmup of 4 steps repeats and buffered words are never delivered.
- With the buffer forced empty by a bench-held generator model, req=4'b1000 → no gnt until a word is pushed, then gnt=1000 with that word exactly 1 cycle later.
